neosd_data_fifo: RTL and testbench

Parametrised Wishbone-attached data buffer between the CPU bus and the neosd DAT-line state machine. It replaces the single-word, flag-handshaked data register with a configurable-depth FWFT FIFO. The FIFO serves one direction at a time: TX (bus→card) or RX (card→bus). The block adds a watermark interrupt, overflow/underflow reporting, a maskable `irq_o`, and a valid/ready stream toward the DAT FSM.

---
 rtl/neosd_data_fifo.sv | 184 ++++++++++++++++++
 tb/tb_neosd_data_fifo.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neosd_data_fifo.sv
// neosd_data_fifo: FWFT word buffer between Wishbone and the neosd DAT FSM, one direction (TX or RX) at a time.
// Latency: bus ack/err/read data one cycle after acceptance; a pushed word is at the head one cycle later.
// Backpressure: default build drops/errs on full write or empty read; NEOSD_FIFO_STALL_EN stalls the bus instead.
module neosd_data_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int WATERMARK  = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_stall_o,
  output logic [31:0] wb_dat_o,
  output logic        irq_o,
  output logic [31:0] tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [31:0] rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [7:0] ADR_CTRL   = 8'h00;
  localparam logic [7:0] ADR_STATUS = 8'h04;
  localparam logic [7:0] ADR_FLAG   = 8'h08;
  localparam logic [7:0] ADR_MASK   = 8'h0C;
  localparam logic [7:0] ADR_DATA   = 8'h10;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          dir_q, dir_d;
  logic [2:0]    mask_q, mask_d, flag_q, flag_d;
  logic          wm_prev_q;
  logic          ack_q, ack_d, err_q, err_d, irq_q, irq_d;
  logic [31:0]   rdat_q, rdat_d;

  logic [7:0]    adr;
  logic          full, empty, accept, sel_data;
  logic          bus_wr, bus_rd, data_wr_tx, data_rd_rx;
  logic          ovf_ev, unf_ev, bus_push, bus_pop, tx_pop, rx_push;
  logic          push, pop, ctrl_wr, flush, wm_cond;
  logic [2:0]    flag_clr, flag_set;
  logic [31:0]   head, push_dat;

  // Byte selects, cycle and the upper address are not decoded: every access is a full word.
  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:8], wb_cyc_i};

  assign adr      = wb_adr_i[7:0];
  assign full     = (level_q == LW'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign sel_data = (adr == ADR_DATA);
  assign head     = mem_q[rptr_q];

`ifdef NEOSD_FIFO_STALL_EN
  // Hold the bus on a DATA access that cannot complete yet; it never errors.
  assign wb_stall_o = wb_stb_i & sel_data &
                      ((wb_we_i & ~dir_q & full) | (~wb_we_i & dir_q & empty));
`else
  assign wb_stall_o = 1'b0;
`endif

  assign accept     = wb_stb_i & ~wb_stall_o;
  assign bus_wr     = accept & wb_we_i;
  assign bus_rd     = accept & ~wb_we_i;
  assign data_wr_tx = bus_wr & sel_data & ~dir_q;
  assign data_rd_rx = bus_rd & sel_data & dir_q;

`ifdef NEOSD_FIFO_STALL_EN
  assign ovf_ev = 1'b0;
  assign unf_ev = 1'b0;
`else
  assign ovf_ev = data_wr_tx & full;
  assign unf_ev = data_rd_rx & empty;
`endif

  assign bus_push = data_wr_tx & ~full;
  assign bus_pop  = data_rd_rx & ~empty;

  assign tx_valid_o = ~dir_q & ~empty;
  assign rx_ready_o = dir_q & ~full;
  assign tx_data_o  = tx_valid_o ? head : 32'h0;
  assign tx_pop     = tx_valid_o & tx_ready_i;
  assign rx_push    = rx_valid_i & rx_ready_o;

  assign push     = bus_push | rx_push;
  assign pop      = bus_pop | tx_pop;
  assign push_dat = dir_q ? rx_data_i : wb_dat_i;

  // A direction change also empties the buffer so stale words never leak the other way.
  assign ctrl_wr = bus_wr & (adr == ADR_CTRL);
  assign flush   = ctrl_wr & (wb_dat_i[1] | (wb_dat_i[0] != dir_q));

  assign wm_cond  = dir_q ? (level_q >= LW'(WATERMARK)) : (level_q <= LW'(WATERMARK));
  assign flag_set = {unf_ev, ovf_ev, wm_cond & ~wm_prev_q};
  assign flag_clr = (bus_wr && adr == ADR_FLAG) ? wb_dat_i[2:0] : 3'b000;

  // Next-state for pointers, level, control registers and the registered bus response.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    dir_d   = dir_q;
    mask_d  = mask_q;
    rdat_d  = 32'h0;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      wptr_d  = wptr_q + AW'(push);
      rptr_d  = rptr_q + AW'(pop);
      level_d = level_q + LW'(push) - LW'(pop);
    end
    if (ctrl_wr) dir_d = wb_dat_i[0];
    if (bus_wr && adr == ADR_MASK) mask_d = wb_dat_i[2:0];
    if (bus_rd) begin
      case (adr)
        ADR_CTRL:   rdat_d = {31'h0, dir_q};
        ADR_STATUS: rdat_d = 32'(level_q) | {14'h0, full, empty, 16'h0};
        ADR_FLAG:   rdat_d = {29'h0, flag_q};
        ADR_MASK:   rdat_d = {29'h0, mask_q};
        ADR_DATA:   rdat_d = (dir_q & ~empty) ? head : 32'h0;
        default:    rdat_d = 32'h0;
      endcase
    end
    // A new event in the same cycle as its W1C clear keeps the flag set.
    flag_d = (flag_q & ~flag_clr) | flag_set;
    err_d  = ovf_ev | unf_ev;
    ack_d  = accept & ~err_d;
    irq_d  = |(flag_q & mask_q);
  end

  // Storage is deliberately left out of reset; the pointers alone define its contents.
  always_ff @(posedge clk_i) begin
    if (push && !flush) mem_q[wptr_q] <= push_dat;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      dir_q     <= 1'b0;
      mask_q    <= 3'b000;
      flag_q    <= 3'b000;
      // An empty TX buffer already sits below the watermark, so leaving reset is not an edge.
      wm_prev_q <= 1'b1;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
      rdat_q    <= 32'h0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      dir_q     <= dir_d;
      mask_q    <= mask_d;
      flag_q    <= flag_d;
      wm_prev_q <= wm_cond;
      ack_q     <= ack_d;
      err_q     <= err_d;
      irq_q     <= irq_d;
      rdat_q    <= rdat_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = rdat_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_neosd_data_fifo.sv
// tb_neosd_data_fifo: directed steps plus a randomized phase, checked every cycle against a queue model.
// Latency: model predicts registered bus response and stream outputs one edge after the inputs.
// Backpressure: covers both drop/err and stall builds through NEOSD_FIFO_STALL_EN.
`timescale 1ns/1ps
module tb_neosd_data_fifo;

  localparam int DEPTH = 16;
  localparam int WM    = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] wb_adr = '0, wb_dat_w = '0;
  logic        wb_we = 1'b0, wb_stb = 1'b0, wb_cyc = 1'b0;
  logic [3:0]  wb_sel = 4'hF;
  logic        wb_ack, wb_err, wb_stall, irq, tx_vld, rx_rdy;
  logic [31:0] wb_dat_r, tx_dat;
  logic        tx_rdy = 1'b0, rx_vld = 1'b0;
  logic [31:0] rx_dat = '0;

  int checks = 0;
  int errors = 0;

  neosd_data_fifo #(.FIFO_DEPTH(DEPTH), .WATERMARK(WM)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_we_i(wb_we), .wb_sel_i(wb_sel),
    .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc),
    .wb_ack_o(wb_ack), .wb_err_o(wb_err), .wb_stall_o(wb_stall), .wb_dat_o(wb_dat_r),
    .irq_o(irq),
    .tx_data_o(tx_dat), .tx_valid_o(tx_vld), .tx_ready_i(tx_rdy),
    .rx_data_i(rx_dat), .rx_valid_i(rx_vld), .rx_ready_o(rx_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference model: buffer contents as a queue plus the architectural registers.
  logic [31:0] q[$];
  logic        m_dir = 1'b0, m_prev = 1'b1, m_irq = 1'b0, m_ack = 1'b0, m_err = 1'b0;
  logic [2:0]  m_mask = 3'b0, m_flag = 3'b0;
  logic [31:0] m_rdat = '0;
  bit          last_acc;
  logic        last_err;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", name, obs, exp);
    end
  endtask

  task automatic chk1(input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b required %b", name, obs, exp);
    end
  endtask

  // One clock cycle: predict from the driven inputs, advance, compare every output.
  task automatic tick();
    int          lvl;
    bit          st, acc, ovf, unf, bpush, bpop, tpop, rpush, flush, cond, nd;
    logic [2:0]  clr, setf, nmask;
    logic [31:0] rd, head;
    logic [7:0]  a;
    bit          evld;
    #1;
    lvl = q.size();
    a   = wb_adr[7:0];
    st  = 1'b0;
`ifdef NEOSD_FIFO_STALL_EN
    st = wb_stb && (a == 8'h10) &&
         ((wb_we && !m_dir && lvl == DEPTH) || (!wb_we && m_dir && lvl == 0));
`endif
    chk1("stall", wb_stall, st);
    acc      = wb_stb && !st;
    last_acc = acc;
    if (!rstn) begin
      q.delete();
      m_dir = 1'b0; m_mask = 3'b0; m_flag = 3'b0; m_prev = 1'b1;
      m_irq = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_rdat = '0;
    end else begin
      head = (lvl > 0) ? q[0] : 32'h0;
      rd = '0; ovf = 0; unf = 0; bpush = 0; bpop = 0; flush = 0; clr = '0;
      nd = m_dir; nmask = m_mask;
      tpop  = !m_dir && lvl > 0 && tx_rdy;
      rpush = m_dir && lvl < DEPTH && rx_vld;
      if (acc) begin
        case (a)
          8'h00: if (wb_we) begin
                   flush = wb_dat_w[1] || (wb_dat_w[0] != m_dir);
                   nd = wb_dat_w[0];
                 end else rd = {31'h0, m_dir};
          8'h04: if (!wb_we) rd = 32'(lvl) | ((lvl == 0) ? 32'h1_0000 : 32'h0) |
                                  ((lvl == DEPTH) ? 32'h2_0000 : 32'h0);
          8'h08: if (wb_we) clr = wb_dat_w[2:0]; else rd = {29'h0, m_flag};
          8'h0C: if (wb_we) nmask = wb_dat_w[2:0]; else rd = {29'h0, m_mask};
          8'h10: if (wb_we) begin
                   if (!m_dir) begin
                     if (lvl == DEPTH) ovf = 1; else bpush = 1;
                   end
                 end else if (m_dir) begin
                   if (lvl == 0) unf = 1;
                   else begin bpop = 1; rd = head; end
                 end
          default: ;
        endcase
      end
      cond   = m_dir ? (lvl >= WM) : (lvl <= WM);
      setf   = {unf, ovf, cond && !m_prev};
      m_prev = cond;
      m_irq  = |(m_flag & m_mask);
      m_flag = (m_flag & ~clr) | setf;
      m_mask = nmask;
      m_dir  = nd;
      m_err  = ovf || unf;
      m_ack  = acc && !m_err;
      m_rdat = rd;
      if (flush) q.delete();
      else begin
        if (tpop || bpop) void'(q.pop_front());
        if (bpush) q.push_back(wb_dat_w);
        if (rpush) q.push_back(rx_dat);
      end
    end
    @(posedge clk); #1;
    evld = !m_dir && q.size() > 0;
    chk1("ack", wb_ack, m_ack);
    chk1("err", wb_err, m_err);
    chk("rdata", wb_dat_r, m_rdat);
    chk1("irq", irq, m_irq);
    chk1("tx_valid", tx_vld, evld);
    chk("tx_data", tx_dat, evld ? q[0] : 32'h0);
    chk1("rx_ready", rx_rdy, m_dir && q.size() < DEPTH);
  endtask

  task automatic wb_issue(input logic we, input logic [7:0] adr, input logic [31:0] dat);
    wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = we;
    wb_adr = {24'h0, adr}; wb_dat_w = dat;
  endtask

  task automatic wb_finish(output logic [31:0] rd);
    int n = 0;
    last_acc = 0;
    while (!last_acc && n < 40) begin
      tick();
      n++;
    end
    chk1("wb_accept_in_time", last_acc, 1'b1);
    rd = wb_dat_r;
    last_err = wb_err;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                    output logic [31:0] rd);
    wb_issue(we, adr, dat);
    wb_finish(rd);
  endtask

  logic [31:0] rd;
  logic [31:0] rxw [4];

  initial begin
    // Reset and idle state
    rstn = 1'b0;
    repeat (2) tick();
    chk1("reset_tx_valid", tx_vld, 1'b0);
    chk1("reset_irq", irq, 1'b0);
    rstn = 1'b1;
    tick();
    wb(1'b0, 8'h04, 32'h0, rd);
    chk("reset_status", rd, 32'h0001_0000);
    chk1("idle_irq", irq, 1'b0);
    chk1("idle_tx_valid", tx_vld, 1'b0);

    // TX fill to full with WMARK unmasked
    wb(1'b1, 8'h0C, 32'h1, rd);
    for (int i = 1; i <= DEPTH; i++) wb(1'b1, 8'h10, 32'(i), rd);
    wb(1'b0, 8'h04, 32'h0, rd);
    chk("tx_full_status", rd, 32'h0002_0010);

    // Write while full
`ifdef NEOSD_FIFO_STALL_EN
    wb_issue(1'b1, 8'h10, 32'hDEAD);
    #1 chk1("tx_full_stall", wb_stall, 1'b1);
    tick(); tick();
    tx_rdy = 1'b1; tick(); tx_rdy = 1'b0;
    wb_finish(rd);
    chk1("tx_stall_no_err", last_err, 1'b0);
    wb(1'b0, 8'h04, 32'h0, rd);
    chk("tx_refill_status", rd, 32'h0002_0010);
    chk("tx_head_after_stall", tx_dat, 32'h2);
`else
    wb(1'b1, 8'h10, 32'hDEAD, rd);
    chk1("ovf_err", last_err, 1'b1);
    wb(1'b0, 8'h04, 32'h0, rd);
    chk("ovf_level_kept", rd, 32'h0002_0010);
    wb(1'b0, 8'h08, 32'h0, rd);
    chk("ovf_flag", rd & 32'h2, 32'h2);
    chk("tx_head_first", tx_dat, 32'h1);
`endif

    // Drain through the stream port; WMARK fires as level reaches 8
    tx_rdy = 1'b1;
    repeat (DEPTH + 2) tick();
    tx_rdy = 1'b0;
    chk1("drain_tx_valid", tx_vld, 1'b0);
    wb(1'b0, 8'h08, 32'h0, rd);
    chk("wmark_tx_flag", rd & 32'h1, 32'h1);
    chk1("wmark_tx_irq", irq, 1'b1);

    // RX: three words in, four bus reads out
    wb(1'b1, 8'h00, 32'h1, rd);
    for (int i = 0; i < 4; i++) rxw[i] = $urandom;
    rx_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_dat = rxw[i];
      tick();
    end
    rx_vld = 1'b0;
    wb(1'b0, 8'h04, 32'h0, rd);
    chk("rx_level3", rd, 32'h0000_0003);
    for (int i = 0; i < 3; i++) begin
      wb(1'b0, 8'h10, 32'h0, rd);
      chk("rx_read_word", rd, rxw[i]);
    end
`ifdef NEOSD_FIFO_STALL_EN
    wb_issue(1'b0, 8'h10, 32'h0);
    #1 chk1("rx_empty_stall", wb_stall, 1'b1);
    tick(); tick();
    rx_vld = 1'b1; rx_dat = rxw[3]; tick(); rx_vld = 1'b0;
    wb_finish(rd);
    chk("rx_read_after_stall", rd, rxw[3]);
`else
    wb(1'b0, 8'h10, 32'h0, rd);
    chk("unf_data", rd, 32'h0);
    chk1("unf_err", last_err, 1'b1);
    wb(1'b0, 8'h08, 32'h0, rd);
    chk("unf_flag", rd & 32'h4, 32'h4);
`endif

    // W1C of all flags in the same cycle as a fresh WMARK edge (RX level 7 -> 8)
    rx_vld = 1'b1;
    for (int i = 0; i < WM; i++) begin
      rx_dat = $urandom;
      tick();
    end
    rx_vld = 1'b0;
    wb(1'b1, 8'h08, 32'h7, rd);
    wb(1'b0, 8'h08, 32'h0, rd);
    chk("w1c_vs_set", rd, 32'h1);

    // Flush with level 5 while the DAT FSM is popping
    wb(1'b1, 8'h00, 32'h0, rd);
    for (int i = 0; i < 5; i++) wb(1'b1, 8'h10, $urandom, rd);
    tx_rdy = 1'b1;
    wb(1'b1, 8'h00, 32'h2, rd);
    chk1("flush_tx_valid", tx_vld, 1'b0);
    tx_rdy = 1'b0;
    wb(1'b0, 8'h04, 32'h0, rd);
    chk("flush_status", rd, 32'h0001_0000);

    // Reset in the middle of a stream
    tx_rdy = 1'b1;
    for (int i = 0; i < 4; i++) wb(1'b1, 8'h10, $urandom, rd);
    wb(1'b1, 8'h10, 32'h1234, rd);
    wb_issue(1'b1, 8'h10, 32'h5678);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0; tx_rdy = 1'b0;
    #1;
    chk1("rst_ack", wb_ack, 1'b0);
    chk1("rst_err", wb_err, 1'b0);
    chk("rst_rdata", wb_dat_r, 32'h0);
    chk1("rst_irq", irq, 1'b0);
    chk1("rst_tx_valid", tx_vld, 1'b0);
    chk("rst_tx_data", tx_dat, 32'h0);
    chk1("rst_rx_ready", rx_rdy, 1'b0);
    chk1("rst_stall", wb_stall, 1'b0);

    // Randomized traffic on every port, one decision per cycle
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel    = $urandom_range(0, 19);
      wb_stb = ($urandom_range(0, 99) < 60);
      wb_cyc = wb_stb;
      wb_we  = 1'($urandom_range(0, 1));
      wb_dat_w = $urandom;
      if (sel == 0)       wb_adr[7:0] = 8'h00;
      else if (sel <= 2)  wb_adr[7:0] = 8'h04;
      else if (sel == 3)  wb_adr[7:0] = 8'h08;
      else if (sel == 4)  wb_adr[7:0] = 8'h0C;
      else if (sel <= 17) wb_adr[7:0] = 8'h10;
      else                wb_adr[7:0] = 8'($urandom_range(5, 63) * 4);
      wb_adr[31:8] = 24'($urandom);
      tx_rdy = (i < 200) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
      rx_vld = 1'($urandom_range(0, 1));
      rx_dat = $urandom;
      tick();
    end
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0; tx_rdy = 1'b0; rx_vld = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
